// File: rtl/axi_pkg.sv
// Shared AXI definitions for the instruction sender/receiver pair.
// Contents: burst and response encodings, the sender FSM state enum, and
// a helper that derives AxSIZE from a data-bus width in bits.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // AxSIZE is log2 of the bytes per beat: 64-bit bus -> 8 bytes -> 3.
  function automatic logic [2:0] axi_size_from_width(input int unsigned width_bits);
    return 3'($clog2(width_bits / 8));
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter for one AXI burst.
// Ports:
//   clk, rst    clock and synchronous active-low reset
//   load_i      capture len_i and restart the count at beat 0
//   len_i       burst length in AXI LEN encoding (beats minus 1)
//   inc_i       one data handshake happened this cycle
//   len_o       captured length, drives AxLEN
//   last_o      current beat is the final beat of the burst
module axi_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] len_i,
  input  logic       inc_i,
  output logic [7:0] len_o,
  output logic       last_o
);

  logic [7:0] count_q;
  logic [7:0] len_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      len_q   <= '0;
    end else if (load_i) begin
      count_q <= '0;
      len_q   <= len_i;
    end else if (inc_i && !last_o) begin
      // Holding at the final beat keeps len=255 from wrapping to 0.
      count_q <= count_q + 8'd1;
    end
  end

  assign len_o  = len_q;
  assign last_o = (count_q == len_q);

endmodule

// File: rtl/axi_inst_sender.sv
// AXI4 full master feeding the instruction receiver's slave port.
// Takes one command at a time (write or read burst), streams write beats
// from src_* or read beats into snk_*, then pulses done with status.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cmd_*                    command handshake and fields (write, addr, len, id)
//   src_*                    write-beat stream into the W channel
//   snk_*                    read-beat stream out of the R channel
//   done, done_resp, done_err  one-cycle completion pulse with status
//   M_AXI_*                  AXI4 master AW/W/B/AR/R channels
module axi_inst_sender
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,

  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic                    src_valid,
  output logic                    src_ready,

  output logic [DATA_WIDTH-1:0]   snk_data,
  output logic                    snk_valid,
  input  logic                    snk_ready,
  output logic                    snk_last,

  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_err,

  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] BEAT_SIZE  = axi_size_from_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;

  logic                  cnt_load;
  logic                  beat_fire;
  logic [7:0]            burst_len;
  logic                  beat_last;

  axi_beat_counter u_beat_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .len_i  (cmd_len),
    .inc_i  (beat_fire),
    .len_o  (burst_len),
    .last_o (beat_last)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    id_d          = id_q;
    resp_d        = resp_q;
    err_d         = err_q;
    cnt_load      = 1'b0;
    beat_fire     = 1'b0;
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    src_ready     = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_RREADY  = 1'b0;
    snk_valid     = 1'b0;
    snk_last      = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // rst is active-low: no command is offered while reset is held.
        cmd_ready = rst;
        if (cmd_valid) begin
          cnt_load = 1'b1;
          addr_d   = cmd_addr;
          id_d     = cmd_id;
          resp_d   = AXI_RESP_OKAY;
          err_d    = 1'b0;
          state_d  = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end

      ST_WR_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_d = ST_WR_DATA;
      end

      ST_WR_DATA: begin
        M_AXI_WVALID = src_valid;
        src_ready    = M_AXI_WREADY;
        if (src_valid && M_AXI_WREADY) begin
          beat_fire = 1'b1;
          if (beat_last) state_d = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          err_d   = (M_AXI_BID != id_q) || (M_AXI_BRESP != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end

      ST_RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        M_AXI_RREADY = snk_ready;
        snk_valid    = M_AXI_RVALID;
        snk_last     = M_AXI_RLAST;
        if (M_AXI_RVALID && snk_ready) begin
          beat_fire = 1'b1;
          resp_d    = resp_q | M_AXI_RRESP;
          // RLAST must appear on exactly the final counted beat.
          if ((M_AXI_RID != id_q) || (M_AXI_RLAST != beat_last)) err_d = 1'b1;
          if (beat_last) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      resp_q  <= AXI_RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Address-channel fields come from registers so they hold until the handshake.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWID    = id_q;
  assign M_AXI_AWLEN   = burst_len;
  assign M_AXI_AWSIZE  = BEAT_SIZE;
  assign M_AXI_AWBURST = AXI_BURST_INCR;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARID    = id_q;
  assign M_AXI_ARLEN   = burst_len;
  assign M_AXI_ARSIZE  = BEAT_SIZE;
  assign M_AXI_ARBURST = AXI_BURST_INCR;

  assign M_AXI_WDATA   = src_data;
  assign M_AXI_WSTRB   = {STRB_WIDTH{1'b1}};
  assign M_AXI_WLAST   = beat_last;

  assign snk_data      = M_AXI_RDATA;

  // Status is only presented alongside the done pulse.
  assign done_resp     = done ? resp_q : AXI_RESP_OKAY;
  assign done_err      = done & err_q;

endmodule

// File: tb/tb_axi_inst_sender.sv
module tb_axi_inst_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_id = '0;
  logic [63:0] src_data = '0;
  logic        src_valid = 1'b0, src_ready;
  logic [63:0] snk_data;
  logic        snk_valid, snk_ready = 1'b0, snk_last;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [63:0] awaddr, araddr, wdata;
  logic [3:0]  awid, arid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  axi_inst_sender dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_last(snk_last),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Source data, slave read-response tables.
  logic [63:0] src_mem [256];
  logic [63:0] rd_data [256];
  logic [3:0]  rd_id   [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];

  // ---------------- transaction-level model and per-cycle compare ----------
  // Phase: 0 idle, 1 address, 2 data, 3 write response, 4 done due.
  int          ph = 0;
  bit          m_wr;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [3:0]  m_id;
  int          m_beat;
  logic [1:0]  m_resp;
  bit          m_err;
  int          cyc_n = 0, last_done_cyc = 0, b2b_gap = 0;
  int          done_cnt = 0, w_beats = 0, r_beats = 0;
  logic [1:0]  last_resp = '0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    if (!rst) begin
      ph = 0;
    end else begin
      check("cmd_ready", cmd_ready, ph == 0);
      check("awvalid", awvalid, ph == 1 && m_wr);
      check("arvalid", arvalid, ph == 1 && !m_wr);
      if (ph == 1 && m_wr) begin
        check("awaddr", awaddr, m_addr);
        check("awid", awid, m_id);
        check("awlen", awlen, m_len);
        check("awsize", awsize, 3);
        check("awburst", awburst, 1);
      end
      if (ph == 1 && !m_wr) begin
        check("araddr", araddr, m_addr);
        check("arid", arid, m_id);
        check("arlen", arlen, m_len);
        check("arsize", arsize, 3);
        check("arburst", arburst, 1);
      end
      check("wvalid", wvalid, (ph == 2 && m_wr) ? src_valid : 1'b0);
      check("src_ready", src_ready, (ph == 2 && m_wr) ? wready : 1'b0);
      check("rready", rready, (ph == 2 && !m_wr) ? snk_ready : 1'b0);
      check("snk_valid", snk_valid, (ph == 2 && !m_wr) ? rvalid : 1'b0);
      check("bready", bready, ph == 3);
      check("done", done, ph == 4);
      check("done_resp", done_resp, (ph == 4) ? m_resp : 2'b00);
      check("done_err", done_err, (ph == 4) ? m_err : 1'b0);

      case (ph)
        0: if (cmd_valid && cmd_ready) begin
             m_wr = cmd_write; m_addr = cmd_addr; m_len = cmd_len; m_id = cmd_id;
             m_beat = 0; m_resp = 2'b00; m_err = 1'b0;
             b2b_gap = cyc_n - last_done_cyc;
             ph = 1;
           end
        1: if ((m_wr && awvalid && awready) || (!m_wr && arvalid && arready)) ph = 2;
        2: if (m_wr && wvalid && wready) begin
             check("wdata", wdata, src_mem[m_beat]);
             check("wstrb", wstrb, 8'hFF);
             check("wlast", wlast, m_beat == int'(m_len));
             w_beats++;
             m_beat++;
             if (m_beat > int'(m_len)) ph = 3;
           end else if (!m_wr && rvalid && rready) begin
             check("snk_data", snk_data, rdata);
             check("snk_last", snk_last, rlast);
             r_beats++;
             m_resp = m_resp | rresp;
             if (rid != m_id || rlast != (m_beat == int'(m_len))) m_err = 1'b1;
             if (m_beat == int'(m_len)) ph = 4;
             m_beat++;
           end
        3: if (bvalid && bready) begin
             m_resp = bresp;
             m_err  = (bid != m_id) || (bresp != 2'b00);
             ph = 4;
           end
        4: begin
             done_cnt++;
             last_resp = done_resp;
             last_err  = done_err;
             last_done_cyc = cyc_n;
             ph = 0;
           end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill_read(input int n, input logic [3:0] id);
    for (int i = 0; i < n; i++) begin
      rd_data[i] = 64'hC0DE_0000_0000_0000 + 64'(i * 17);
      rd_id[i]   = id;
      rd_resp[i] = 2'b00;
      rd_last[i] = (i == n - 1);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input bit stall, input int abort_at,
                         input bit wait_done, input logic [1:0] bresp_v, input logic [3:0] bid_v);
    int  guard, beat, cyc, n;
    bit  hs, seen;
    n = int'(len) + 1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    hs = 0; guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk); hs = cmd_ready;
      @(posedge clk); #1; guard++;
    end
    cmd_valid = 1'b0;
    if (!hs) begin timeout("cmd_accept"); return; end

    // Address channel: ready one cycle after valid is first seen.
    hs = 0; guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk);
      seen = wr ? awvalid : arvalid;
      hs   = wr ? (awvalid && awready) : (arvalid && arready);
      @(posedge clk); #1; guard++;
      if (wr) awready = seen && !hs; else arready = seen && !hs;
    end
    if (!hs) begin timeout("addr_hs"); return; end

    beat = 0; cyc = 0; guard = 0;
    if (wr) begin
      while (beat < n && guard < 400) begin
        src_data  = src_mem[beat];
        src_valid = stall ? (cyc % 3 != 1) : 1'b1;
        wready    = stall ? (cyc % 2 == 0) : 1'b1;
        if (abort_at >= 0 && beat == abort_at) begin
          rst = 1'b0; src_valid = 1'b0; wready = 1'b0;
          return;
        end
        @(negedge clk); if (wvalid && wready) beat++;
        @(posedge clk); #1; cyc++; guard++;
      end
      src_valid = 1'b0; wready = 1'b0;
      if (beat < n) begin timeout("w_beats"); return; end
      hs = 0; cyc = 0; bid = bid_v; bresp = bresp_v;
      while (!hs && cyc < 50) begin
        bvalid = (cyc >= 1);
        @(negedge clk); hs = bvalid && bready;
        @(posedge clk); #1; cyc++;
      end
      bvalid = 1'b0;
      if (!hs) begin timeout("b_hs"); return; end
    end else begin
      while (beat < n && guard < 400) begin
        rvalid = 1'b1; rdata = rd_data[beat]; rid = rd_id[beat];
        rresp = rd_resp[beat]; rlast = rd_last[beat];
        snk_ready = stall ? (cyc % 2 == 0) : 1'b1;
        @(negedge clk); if (rvalid && rready) beat++;
        @(posedge clk); #1; cyc++; guard++;
      end
      rvalid = 1'b0; rlast = 1'b0; snk_ready = 1'b0;
      if (beat < n) begin timeout("r_beats"); return; end
    end

    if (wait_done) begin
      hs = 0; guard = 0;
      while (!hs && guard < 10) begin
        @(negedge clk); hs = done;
        @(posedge clk); #1; guard++;
      end
      if (!hs) timeout("done_wait");
    end
  endtask

  int d0, w0, r0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_done", {done, done_err, done_resp}, 0);
    @(posedge clk); #1; rst = 1'b1;

    // Single write
    src_mem[0] = 64'hDEADBEEF_DEADBEEF;
    d0 = done_cnt; w0 = w_beats;
    run_txn(1, 64'h0, 8'd0, 4'd1, 0, -1, 1, 2'b00, 4'd1);
    $display("txn single_write: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("single_done_cnt", done_cnt - d0, 1);
    check("single_w_beats", w_beats - w0, 1);
    check("single_resp", last_resp, 0);
    check("single_err", last_err, 0);

    // Burst write with stalls
    for (int i = 0; i < 4; i++) src_mem[i] = 64'hA5A5A5A5_00000000 + 64'(i);
    w0 = w_beats;
    run_txn(1, 64'h8, 8'd3, 4'd2, 1, -1, 1, 2'b00, 4'd2);
    $display("txn burst_write: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("burst_w_beats", w_beats - w0, 4);
    check("burst_err", last_err, 0);

    // Burst read with backpressure
    fill_read(5, 4'd3);
    r0 = r_beats;
    run_txn(0, 64'h0, 8'd4, 4'd3, 1, -1, 1, 2'b00, 4'd0);
    $display("txn burst_read: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("read_r_beats", r_beats - r0, 5);
    check("read_resp", last_resp, 0);
    check("read_err", last_err, 0);

    // BRESP=SLVERR on write
    src_mem[0] = 64'h1234;
    run_txn(1, 64'h10, 8'd0, 4'd4, 0, -1, 1, 2'b10, 4'd4);
    $display("txn write_slverr: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("slverr_resp", last_resp, 2);
    check("slverr_err", last_err, 1);

    // Early RLAST on beat 2 of a 5-beat read
    fill_read(5, 4'd3);
    rd_last[2] = 1'b1;
    run_txn(0, 64'h20, 8'd4, 4'd3, 0, -1, 1, 2'b00, 4'd0);
    $display("txn early_rlast: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("early_rlast_err", last_err, 1);

    // RID mismatch
    fill_read(2, 4'd3);
    rd_id[1] = 4'd5;
    run_txn(0, 64'h30, 8'd1, 4'd3, 0, -1, 1, 2'b00, 4'd0);
    $display("txn rid_mismatch: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("rid_err", last_err, 1);

    // Reset mid-burst during beat 2, then a normal command
    for (int i = 0; i < 4; i++) src_mem[i] = 64'h5000 + 64'(i);
    d0 = done_cnt;
    run_txn(1, 64'h40, 8'd3, 4'd6, 0, 2, 1, 2'b00, 4'd6);
    @(posedge clk);
    @(negedge clk);
    $display("txn reset_mid_burst: rst asserted during beat 2");
    check("mid_rst_valids", {awvalid, arvalid, wvalid, bready, rready, src_ready, snk_valid}, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_done", {done, done_err, done_resp}, 0);
    @(posedge clk); #1; rst = 1'b1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_txn(1, 64'h40, 8'd3, 4'd6, 0, -1, 1, 2'b00, 4'd6);
    $display("txn after_reset_write: done_resp=%0d done_err=%0d", last_resp, last_err);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_err", last_err, 0);

    // Back-to-back write then read
    src_mem[0] = 64'h77; src_mem[1] = 64'h88;
    fill_read(2, 4'd8);
    run_txn(1, 64'h100, 8'd1, 4'd7, 0, -1, 0, 2'b00, 4'd7);
    run_txn(0, 64'h200, 8'd1, 4'd8, 0, -1, 1, 2'b00, 4'd0);
    $display("txn back_to_back: accept gap=%0d done_err=%0d", b2b_gap, last_err);
    check("b2b_gap", b2b_gap, 1);
    check("b2b_err", last_err, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_inst_sender.md
Name: axi_inst_sender

Overview:
- AXI4 full master that drives the instruction receiver's slave port from the host/loader side: burst-writes instruction words into the receiver's queue and burst-reads result words back.
- Accepts one command at a time (write or read, address, length), streams data beats from a local source or into a local sink, and reports completion status.
- Sits between the host-side loader logic and the receiver's S_AXI_* port. Single outstanding transaction, no reordering.

Parameters:
- DATA_WIDTH, 64, AXI data width in bits.
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- STRB_WIDTH, DATA_WIDTH/8, derived; not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus 1 (AXI LEN encoding).
- cmd_id  in  ID_WIDTH  AWID/ARID for the transaction.
- src_data/src_valid/src_ready  in/in/out  DATA_WIDTH/1/1  write-beat stream.
- snk_data/snk_valid/snk_ready/snk_last  out/out/in/out  DATA_WIDTH/1/1/1  read-beat stream.
- done  out  1  one-cycle completion pulse.
- done_resp  out  2  worst BRESP/RRESP of the transaction.
- done_err  out  1  response ID mismatch, non-OKAY response, or RLAST misplaced.
- M_AXI_AW{ADDR,ID,LEN,SIZE,BURST,VALID}/AWREADY, M_AXI_W{DATA,STRB,LAST,VALID}/WREADY, M_AXI_B{ID,RESP,VALID}/BREADY, M_AXI_AR{ADDR,ID,LEN,SIZE,BURST,VALID}/ARREADY, M_AXI_R{ID,DATA,RESP,LAST,VALID}/RREADY  standard AXI4 master widths.

Behaviour:
- Reset (rst=0 at an edge): state IDLE, beat counter 0. All VALIDs, BREADY, RREADY, done, done_err 0. done_resp 0. cmd_ready 0 during reset. A reset mid-burst drops all valids on the next cycle with no protocol completion.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/len/id/write and go to WR_ADDR or RD_ADDR.
- WR_ADDR:
  - AWVALID=1; AW fields are registered and stable until AWREADY.
  - AWSIZE=log2(STRB_WIDTH) (3 at 64-bit); AWBURST=2'b01 INCR.
  - On AWREADY, go to WR_DATA. AW always completes before the first W beat.
- WR_DATA:
  - WVALID=src_valid; WDATA=src_data; src_ready=WREADY (combinational pass-through); WSTRB all ones.
  - WLAST=(beat==len).
  - Beat increments on WVALID&WREADY; the last beat goes to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP; err if BID≠id or BRESP≠0. Go to DONE.
- RD_ADDR: mirrors WR_ADDR on the AR channel; go to RD_DATA on ARREADY.
- RD_DATA:
  - RREADY=snk_ready; snk_valid=RVALID; snk_data=RDATA; snk_last=RLAST.
  - Each beat: OR RRESP into the accumulated resp (max severity); err if RID≠id.
  - err if RLAST=1 with beat≠len.
  - On the beat with beat==len, exit to DONE; if RLAST=0 on that beat, err.
- DONE: done=1 for exactly one cycle with done_resp/done_err valid, then IDLE. Latency from the final handshake to done is 1 cycle.
- Back-to-back: a new command is accepted the cycle after DONE (cmd_ready high in IDLE only).
- Beat counter is 8 bits and never wraps; len=255 gives 256 beats.
- Address is passed unchanged; no 4 KB boundary splitting (host responsibility).

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - The FSM state enum.
  - A size-from-width helper function.
- Optional sub-module axi_beat_counter (load len, count handshakes, flag last), reusable by the receiver side. Everything else stays in one module.

Test Plan:
- Single write: cmd(write, addr 0x0, len 0, id 1), src 0xDEADBEEF_DEADBEEF → one AW with LEN=0, SIZE=3, BURST=1; one W with WLAST=1, WSTRB=0xFF; BREADY until B; done with resp 0, err 0.
- Burst write with stalls: cmd(write, 0x8, len 3, id 2), src data 0xA5A5A5A5_00000000+i, src_valid gapped and WREADY toggling → exactly 4 beats in order; WLAST only on beat 3; done 1 cycle after B.
- Burst read with backpressure: cmd(read, 0x0, len 4, id 3), slave returns 5 beats, snk_ready 50% duty → 5 snk beats with matching data; snk_last on the 5th; done, err 0.
- Error responses: BRESP=2 on a write → done_resp=2, err=1. Early RLAST on read beat 2 of len 4 → err=1. RID=5 vs id 3 → err=1.
- Reset mid-burst: drive rst=0 during WR_DATA beat 2 → next cycle all VALID/READY 0, state IDLE; a following command completes normally.
- Back-to-back: write cmd then read cmd held valid → read accepted the cycle after write done; no overlap of AW/AR valids.
